scanline_ctrl: RTL and testbench

- Controller for the scanline-dimming datapath.
- Owns the user dim level (register write or hotkey) and the line counter.
- Applies level changes only at frame boundaries, stepping one level per N frames so that changes fade in.
- Drives the datapath's level and per-line dim flag; sits between the OSD/config registers and the video output stage.

---
 rtl/scanline_ctrl_if.sv | 26 ++
 rtl/scanline_ctrl.sv | 109 ++++++++++
 tb/tb_scanline_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/scanline_ctrl_if.sv
// Control/status bundle between the OSD/config side and the scanline controller.
interface scanline_ctrl_if #(
    parameter int LINE_W = 10
);
    logic              ce_x2;
    logic              hs_in;
    logic              vs_in;
    logic              cfg_we;
    logic [1:0]        cfg_level;
    logic              key_cycle;
    logic [1:0]        scanlines;
    logic              scanline;
    logic [LINE_W-1:0] line_cnt;
    logic [1:0]        target;
    logic              busy;

    modport master (
        output ce_x2, hs_in, vs_in, cfg_we, cfg_level, key_cycle,
        input  scanlines, scanline, line_cnt, target, busy
    );

    modport slave (
        input  ce_x2, hs_in, vs_in, cfg_we, cfg_level, key_cycle,
        output scanlines, scanline, line_cnt, target, busy
    );
endinterface

// File: rtl/scanline_ctrl.sv
// Scanline-dimming controller: line counter, user target level and frame-paced fade.
// Optional macro SCANLINE_ALT_FIELD_EN alternates the dimmed line parity every frame.
module scanline_ctrl #(
    parameter int LINE_W          = 10,
    parameter int FRAMES_PER_STEP = 1
) (
    input logic             clk_sys,
    input logic             reset,
    scanline_ctrl_if.slave  bus
);
    localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

    typedef enum logic {STABLE, STEPPING} state_t;

    state_t            state_q, state_d;
    logic              hs_q, vs_q;
    logic              hs_fall, vs_fall;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [1:0]        target_q, target_d;
    logic [1:0]        level_q, level_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              field_q, field_d;

    assign hs_fall = bus.ce_x2 & hs_q & ~bus.hs_in;
    assign vs_fall = bus.ce_x2 & vs_q & ~bus.vs_in;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= STABLE;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            line_cnt_q  <= '0;
            target_q    <= 2'd0;
            level_q     <= 2'd0;
            frame_cnt_q <= '0;
            field_q     <= 1'b0;
        end else begin
            if (bus.ce_x2) begin
                hs_q <= bus.hs_in;
                vs_q <= bus.vs_in;
            end
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            target_q    <= target_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            field_q     <= field_d;
        end
    end

    // vsync takes priority over hsync when both fall together
    always_comb begin
        line_cnt_d = line_cnt_q;
        if (vs_fall)
            line_cnt_d = '0;
        else if (hs_fall && (line_cnt_q != {LINE_W{1'b1}}))
            line_cnt_d = line_cnt_q + 1'b1;
    end

    always_comb begin
        target_d = target_q;
        if (bus.cfg_we)
            target_d = bus.cfg_level;
        else if (bus.key_cycle)
            target_d = target_q + 2'd1;
    end

    always_comb begin
`ifdef SCANLINE_ALT_FIELD_EN
        field_d = field_q ^ vs_fall;
`else
        field_d = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            STABLE: begin
                if (target_q != level_q) begin
                    state_d     = STEPPING;
                    frame_cnt_d = '0;
                end
            end
            STEPPING: begin
                if (target_q == level_q) begin
                    state_d = STABLE;
                end else if (vs_fall) begin
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = '0;
                        level_d     = (target_q > level_q) ? level_q + 2'd1 : level_q - 2'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            default: state_d = STABLE;
        endcase
    end

    assign bus.scanlines = level_q;
    assign bus.scanline  = line_cnt_q[0] ^ field_q;
    assign bus.line_cnt  = line_cnt_q;
    assign bus.target    = target_q;
    assign bus.busy      = (state_q == STEPPING);
endmodule

// File: tb/tb_scanline_ctrl.sv
// Directed bench for scanline_ctrl: one instance fading per frame, one every two frames.
module tb_scanline_ctrl;
`ifdef SCANLINE_ALT_FIELD_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    scanline_ctrl_if #(.LINE_W(10)) ifa ();
    scanline_ctrl_if #(.LINE_W(3))  ifb ();

    assign ifb.ce_x2     = ifa.ce_x2;
    assign ifb.hs_in     = ifa.hs_in;
    assign ifb.vs_in     = ifa.vs_in;
    assign ifb.cfg_we    = ifa.cfg_we;
    assign ifb.cfg_level = ifa.cfg_level;
    assign ifb.key_cycle = ifa.key_cycle;

    scanline_ctrl #(.LINE_W(10), .FRAMES_PER_STEP(1)) dut_a (
        .clk_sys(clk), .reset(rst), .bus(ifa.slave));
    scanline_ctrl #(.LINE_W(3), .FRAMES_PER_STEP(2)) dut_b (
        .clk_sys(clk), .reset(rst), .bus(ifb.slave));

    typedef struct {
        logic       ce, hs, vs, we;
        logic [1:0] lvl;
        logic       key;
        int         line;
        int         tgt;
        int         frm;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.ce_x2 = 1'b1; ifa.hs_in = 1'b1; ifa.vs_in = 1'b1;
        ifa.cfg_we = 1'b0; ifa.cfg_level = 2'd0; ifa.key_cycle = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic hs_pulse();
        ifa.hs_in = 1'b0; step();
        ifa.hs_in = 1'b1; step();
    endtask

    task automatic cfg(input logic [1:0] lvl);
        ifa.cfg_we = 1'b1; ifa.cfg_level = lvl; step();
        ifa.cfg_we = 1'b0; ifa.cfg_level = 2'd0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1, 2, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2, 2, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2, 3, 0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3, 3, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 3, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 0, 1, 1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 0, 0, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 0, 1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1, 0, 1};

        idle();
        step();
        chk("rst_scanlines", ifa.scanlines, 0);
        chk("rst_target",    ifa.target,    0);
        chk("rst_line_cnt",  ifa.line_cnt,  0);
        chk("rst_scanline",  ifa.scanline,  0);
        chk("rst_busy",      ifa.busy,      0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            ifa.ce_x2 = tbl[i].ce; ifa.hs_in = tbl[i].hs; ifa.vs_in = tbl[i].vs;
            ifa.cfg_we = tbl[i].we; ifa.cfg_level = tbl[i].lvl; ifa.key_cycle = tbl[i].key;
            step();
            chk($sformatf("vec%0d_line_cnt", i), ifa.line_cnt, tbl[i].line);
            chk($sformatf("vec%0d_target", i), ifa.target, tbl[i].tgt);
            chk($sformatf("vec%0d_scanline", i), ifa.scanline,
                32'(tbl[i].line % 2) ^ (ALT ? 32'(tbl[i].frm % 2) : 32'd0));
        end

        // Fade 0 -> 3, one level per frame
        do_reset();
        hs_pulse();
        hs_pulse();
        cfg(2'd3);
        step();
        chk("up_busy", ifa.busy, 1);
        step();
        chk("up_hold0", ifa.scanlines, 0);
        for (int k = 1; k <= 3; k++) begin
            ifa.vs_in = 1'b0; step();
            chk($sformatf("up_lvl%0d", k), ifa.scanlines, k);
            chk($sformatf("up_busy%0d", k), ifa.busy, 1);
            ifa.vs_in = 1'b1; step();
        end
        chk("up_done_busy", ifa.busy, 0);
        chk("up_line_cnt", ifa.line_cnt, 0);

        // Hotkey 3 -> 0 must fade down, not wrap
        ifa.key_cycle = 1'b1; step();
        ifa.key_cycle = 1'b0;
        chk("dn_target", ifa.target, 0);
        chk("dn_hold3", ifa.scanlines, 3);
        step();
        for (int k = 2; k >= 0; k--) begin
            ifa.vs_in = 1'b0; step();
            chk($sformatf("dn_lvl%0d", k), ifa.scanlines, k);
            ifa.vs_in = 1'b1; step();
        end
        chk("dn_done_busy", ifa.busy, 0);

        // Two frames per step, 0 -> 2
        do_reset();
        cfg(2'd2);
        step();
        for (int k = 1; k <= 4; k++) begin
            ifa.vs_in = 1'b0; step();
            chk($sformatf("f2_lvl_vs%0d", k), ifb.scanlines, k / 2);
            ifa.vs_in = 1'b1; step();
        end
        chk("f2_done_busy", ifb.busy, 0);

        // Target pulled back to current level mid-fade
        do_reset();
        cfg(2'd2);
        step();
        for (int k = 0; k < 2; k++) begin
            ifa.vs_in = 1'b0; step();
            ifa.vs_in = 1'b1; step();
        end
        chk("rev_lvl", ifb.scanlines, 1);
        chk("rev_busy_pre", ifb.busy, 1);
        cfg(2'd1);
        chk("rev_target", ifb.target, 1);
        step();
        chk("rev_busy_drop", ifb.busy, 0);
        for (int k = 0; k < 2; k++) begin
            ifa.vs_in = 1'b0; step();
            ifa.vs_in = 1'b1; step();
        end
        chk("rev_lvl_hold", ifb.scanlines, 1);
        chk("rev_busy_hold", ifb.busy, 0);

        // Line counter saturation on the narrow instance
        do_reset();
        for (int k = 0; k < 9; k++) hs_pulse();
        chk("sat_narrow", ifb.line_cnt, 7);
        chk("sat_wide", ifa.line_cnt, 9);

        // Asynchronous reset in the middle of a fade
        do_reset();
        for (int k = 0; k < 3; k++) hs_pulse();
        cfg(2'd3);
        step();
        ifa.vs_in = 1'b0; step();
        ifa.vs_in = 1'b1; step();
        hs_pulse();
        chk("mid_lvl", ifa.scanlines, 1);
        chk("mid_busy", ifa.busy, 1);
        ifa.ce_x2 = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_scanlines", ifa.scanlines, 0);
        chk("arst_target",    ifa.target,    0);
        chk("arst_line_cnt",  ifa.line_cnt,  0);
        chk("arst_scanline",  ifa.scanline,  0);
        chk("arst_busy",      ifa.busy,      0);
        step();
        rst = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
